// File: rtl/bcd_countdown_timer_pkg.sv
// Shared select codes, digit limits and digit type for the BCD countdown timer.
package timer_pkg;

  localparam logic [1:0] SEL_SEGS0 = 2'd0;
  localparam logic [1:0] SEL_SEGS1 = 2'd1;
  localparam logic [1:0] SEL_MINS0 = 2'd2;
  localparam logic [1:0] SEL_MINS1 = 2'd3;

  localparam logic [3:0] DIG_MAX_9 = 4'd9;
  localparam logic [3:0] DIG_MAX_5 = 4'd5;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_countdown_timer_tick_prescaler.sv
// Modulo-DIV cycle counter; tick is high during the last count while enabled.
// Dropping en clears the count so the next period is a full DIV cycles.
module tick_prescaler #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en & (cnt_q == LAST);

  // next count: cleared when idle or on wrap
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown datapath: button edits while idle, 1 s decrement while running.
// Optional digit-blink strobe is built only when TIMER_BLINK_EN is defined.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned BLINK_DIV = 6_250_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic [1:0] i_choose,
  input  logic       i_B_U,
  input  logic       i_B_D,
  output logic [3:0] o_mins1,
  output logic [3:0] o_mins0,
  output logic [3:0] o_segs1,
  output logic [3:0] o_segs0,
  output logic       o_zero,
  output logic       o_tick,
  output logic       o_blink
);

  if (TICK_DIV < 2 || BLINK_DIV < 1) begin : g_param_check
    $error("bcd_countdown_timer: TICK_DIV must be >= 2 and BLINK_DIV >= 1");
  end

  function automatic bcd_digit_t dig_inc(input bcd_digit_t d, input bcd_digit_t max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic bcd_digit_t dig_dec(input bcd_digit_t d, input bcd_digit_t max);
    return (d == 4'd0) ? max : d - 4'd1;
  endfunction

  bcd_digit_t segs0_q, segs0_d;
  bcd_digit_t segs1_q, segs1_d;
  bcd_digit_t mins0_q, mins0_d;
  bcd_digit_t mins1_q, mins1_d;
  logic       u_prev_q, d_prev_q;
  logic       tick_q;
  logic       u_edge, d_edge, edit_any;
  logic       sec_tick;
  logic       zero_s;

  assign u_edge   = i_B_U & ~u_prev_q;
  assign d_edge   = i_B_D & ~d_prev_q;
  assign edit_any = (u_edge | d_edge) & ~i_run;
  assign zero_s   = (segs0_q == 4'd0) && (segs1_q == 4'd0) &&
                    (mins0_q == 4'd0) && (mins1_q == 4'd0);

  tick_prescaler #(.DIV(TICK_DIV)) u_sec_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (i_run),
    .tick (sec_tick)
  );

  // digit next-state: borrow-chain decrement when running, single-digit wrap edit when idle
  always_comb begin
    segs0_d = segs0_q;
    segs1_d = segs1_q;
    mins0_d = mins0_q;
    mins1_d = mins1_q;
    if (i_run) begin
      if (sec_tick && !zero_s) begin
        segs0_d = dig_dec(segs0_q, DIG_MAX_9);
        if (segs0_q == 4'd0) begin
          segs1_d = dig_dec(segs1_q, DIG_MAX_5);
          if (segs1_q == 4'd0) begin
            mins0_d = dig_dec(mins0_q, DIG_MAX_9);
            if (mins0_q == 4'd0) begin
              mins1_d = dig_dec(mins1_q, DIG_MAX_9);
            end else begin
              mins1_d = mins1_q;
            end
          end else begin
            mins0_d = mins0_q;
          end
        end else begin
          segs1_d = segs1_q;
        end
      end else begin
        segs0_d = segs0_q;
      end
    end else if (u_edge ^ d_edge) begin
      case (i_choose)
        SEL_SEGS0: segs0_d = u_edge ? dig_inc(segs0_q, DIG_MAX_9) : dig_dec(segs0_q, DIG_MAX_9);
        SEL_SEGS1: segs1_d = u_edge ? dig_inc(segs1_q, DIG_MAX_5) : dig_dec(segs1_q, DIG_MAX_5);
        SEL_MINS0: mins0_d = u_edge ? dig_inc(mins0_q, DIG_MAX_9) : dig_dec(mins0_q, DIG_MAX_9);
        SEL_MINS1: mins1_d = u_edge ? dig_inc(mins1_q, DIG_MAX_9) : dig_dec(mins1_q, DIG_MAX_9);
        default:   segs0_d = segs0_q;
      endcase
    end else begin
      segs0_d = segs0_q;
    end
  end

  // digit, edge-detect and tick registers
  always_ff @(posedge clk) begin
    if (reset) begin
      segs0_q  <= 4'd0;
      segs1_q  <= 4'd0;
      mins0_q  <= 4'd0;
      mins1_q  <= 4'd0;
      u_prev_q <= 1'b0;
      d_prev_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      segs0_q  <= segs0_d;
      segs1_q  <= segs1_d;
      mins0_q  <= mins0_d;
      mins1_q  <= mins1_d;
      u_prev_q <= i_B_U;
      d_prev_q <= i_B_D;
      tick_q   <= sec_tick;
    end
  end

`ifdef TIMER_BLINK_EN
  logic blink_q, blink_d;
  logic blink_en, blink_tick;

  // running or editing keeps the selected digit visible and restarts the blink phase
  assign blink_en = ~i_run & ~edit_any;

  tick_prescaler #(.DIV(BLINK_DIV)) u_blink_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (blink_en),
    .tick (blink_tick)
  );

  // blink toggle next-state
  always_comb begin
    if (!blink_en) begin
      blink_d = 1'b0;
    end else begin
      blink_d = blink_q ^ blink_tick;
    end
  end

  // blink register
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign o_blink = blink_q;
`else
  assign o_blink = 1'b0;
`endif

  assign o_segs0 = segs0_q;
  assign o_segs1 = segs1_q;
  assign o_mins0 = mins0_q;
  assign o_mins1 = mins1_q;
  assign o_zero  = zero_s;
  assign o_tick  = tick_q;

endmodule
